// File: rtl/band_playback_scheduler.sv
// Shares one single-port band ROM across NUM_BANDS channels, reading one sample per enabled band per 44 kHz strobe.
// Build option: BAND_SCHED_LOOP_EN selects looping playback; undefined gives one-shot playback.
module band_playback_scheduler #(
  parameter int unsigned NUM_BANDS    = 4,
  parameter int unsigned BAND_DEPTH   = 4036,
  parameter int unsigned CLK_DIV      = 100,
  parameter int unsigned BRAM_LAT     = 1,
  parameter int unsigned ADDR_WIDTH   = $clog2(NUM_BANDS * BAND_DEPTH),
  parameter bit          TIMING_CHECK = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      run,
  input  logic [NUM_BANDS-1:0]      band_mask,
  output logic [ADDR_WIDTH-1:0]     rom_addr,
  input  logic [15:0]               rom_dout,
  output logic                      sample_tick,
  output logic [NUM_BANDS*16-1:0]   band_data,
  output logic [NUM_BANDS-1:0]      band_valid,
  output logic                      frame_valid,
  output logic                      busy,
  output logic                      done,
  output logic                      overrun
);

  localparam int unsigned CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned IDX_W   = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
  localparam int unsigned PH_W    = (BAND_DEPTH > 1) ? $clog2(BAND_DEPTH) : 1;
  localparam int unsigned LAT_W   = (BRAM_LAT > 1) ? $clog2(BRAM_LAT) : 1;
  localparam int unsigned MIN_DIV = NUM_BANDS * (BRAM_LAT + 2) + 2;

  // A full frame must fit between two strobes; TIMING_CHECK=0 allows deliberately overrunning setups.
  if (TIMING_CHECK && (CLK_DIV < MIN_DIV)) begin : g_div_check
    $error("band_playback_scheduler: CLK_DIV too small for NUM_BANDS and BRAM_LAT");
  end

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, DONE} state_t;

  state_t                 state;
  logic [CNT_W-1:0]       tick_cnt;
  logic [NUM_BANDS-1:0]   mask_q;
  logic [IDX_W-1:0]       idx;
  logic [ADDR_WIDTH-1:0]  base;
  logic [PH_W-1:0]        phase;
  logic [LAT_W-1:0]       wait_cnt;
  logic                   last_band;
  logic                   at_end;
  logic                   advance;
  logic                   done_block;

  assign last_band = (idx == IDX_W'(NUM_BANDS - 1));
  assign at_end    = (phase == PH_W'(BAND_DEPTH - 1));
  assign advance   = ((state == ISSUE) && !mask_q[idx]) || (state == CAPTURE);

`ifdef BAND_SCHED_LOOP_EN
  assign done_block = 1'b0;
`else
  logic run_q;
  assign done_block = done;
`endif

  // Strobe generator: counter idles at 0 while paused, strobe follows the terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt    <= '0;
      sample_tick <= 1'b0;
    end else if (!run) begin
      tick_cnt    <= '0;
      sample_tick <= 1'b0;
    end else if (tick_cnt == CNT_W'(CLK_DIV - 1)) begin
      tick_cnt    <= '0;
      sample_tick <= 1'b1;
    end else begin
      tick_cnt    <= tick_cnt + CNT_W'(1);
      sample_tick <= 1'b0;
    end
  end

  // Frame sequencer: walks the bands, issuing reads for enabled ones and clearing disabled ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mask_q      <= '0;
      idx         <= '0;
      base        <= '0;
      phase       <= '0;
      wait_cnt    <= '0;
      rom_addr    <= '0;
      band_data   <= '0;
      band_valid  <= '0;
      frame_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      overrun     <= 1'b0;
`ifndef BAND_SCHED_LOOP_EN
      run_q       <= 1'b0;
`endif
    end else begin
      frame_valid <= 1'b0;
      if (sample_tick && busy && !done_block) overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (sample_tick && !done_block) begin
            state  <= ISSUE;
            busy   <= 1'b1;
            mask_q <= band_mask;
            idx    <= '0;
            base   <= '0;
          end
        end
        ISSUE: begin
          if (mask_q[idx]) begin
            rom_addr <= base + ADDR_WIDTH'(phase);
            wait_cnt <= '0;
            state    <= WAIT;
          end else begin
            band_data[int'(idx)*16 +: 16] <= 16'h0000;
            band_valid[idx]               <= 1'b0;
          end
        end
        WAIT: begin
          if (wait_cnt == LAT_W'(BRAM_LAT - 1)) state <= CAPTURE;
          else wait_cnt <= wait_cnt + LAT_W'(1);
        end
        CAPTURE: begin
          band_data[int'(idx)*16 +: 16] <= rom_dout;
          band_valid[idx]               <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
`ifdef BAND_SCHED_LOOP_EN
          done  <= 1'b0;
          phase <= at_end ? '0 : phase + PH_W'(1);
`else
          if (!at_end) phase <= phase + PH_W'(1);
`endif
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      if (advance) begin
        if (last_band) begin
          state       <= DONE;
          frame_valid <= 1'b1;
`ifdef BAND_SCHED_LOOP_EN
          done        <= at_end;
`else
          if (at_end) done <= 1'b1;
`endif
        end else begin
          idx   <= idx + IDX_W'(1);
          base  <= base + ADDR_WIDTH'(BAND_DEPTH);
          state <= ISSUE;
        end
      end

`ifndef BAND_SCHED_LOOP_EN
      // Restart of one-shot playback on a fresh run request.
      run_q <= run;
      if (run && !run_q) begin
        done  <= 1'b0;
        phase <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_band_playback_scheduler.sv
// Directed self-checking bench for band_playback_scheduler: main, overrun and short-band instances.
module tb_band_playback_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // main instance (default parameters)
  logic        run_m = 1'b0;
  logic [3:0]  mask_m = 4'hF;
  logic [13:0] addr_m;
  logic [15:0] dout_m;
  logic        tick_m, fv_m, busy_m, done_m, ovr_m;
  logic [63:0] data_m;
  logic [3:0]  valid_m;

  // overrun instance
  logic        run_o = 1'b0;
  logic [3:0]  mask_o = 4'hF;
  logic [13:0] addr_o;
  logic [15:0] dout_o;
  logic        tick_o, fv_o, busy_o, done_o, ovr_o;
  logic [63:0] data_o;
  logic [3:0]  valid_o;

  // short band instance for phase wrap
  logic        run_w = 1'b0;
  logic [3:0]  mask_w = 4'hF;
  logic [3:0]  addr_w;
  logic [15:0] dout_w;
  logic        tick_w, fv_w, busy_w, done_w, ovr_w;
  logic [63:0] data_w;
  logic [3:0]  valid_w;

  band_playback_scheduler u_main (
    .clk(clk), .rst_n(rst_n), .run(run_m), .band_mask(mask_m), .rom_addr(addr_m),
    .rom_dout(dout_m), .sample_tick(tick_m), .band_data(data_m), .band_valid(valid_m),
    .frame_valid(fv_m), .busy(busy_m), .done(done_m), .overrun(ovr_m)
  );

  band_playback_scheduler #(.CLK_DIV(8), .TIMING_CHECK(1'b0)) u_ovr (
    .clk(clk), .rst_n(rst_n), .run(run_o), .band_mask(mask_o), .rom_addr(addr_o),
    .rom_dout(dout_o), .sample_tick(tick_o), .band_data(data_o), .band_valid(valid_o),
    .frame_valid(fv_o), .busy(busy_o), .done(done_o), .overrun(ovr_o)
  );

  band_playback_scheduler #(.BAND_DEPTH(4), .CLK_DIV(16)) u_wrap (
    .clk(clk), .rst_n(rst_n), .run(run_w), .band_mask(mask_w), .rom_addr(addr_w),
    .rom_dout(dout_w), .sample_tick(tick_w), .band_data(data_w), .band_valid(valid_w),
    .frame_valid(fv_w), .busy(busy_w), .done(done_w), .overrun(ovr_w)
  );

  // 1-cycle ROMs whose contents equal their address
  always_ff @(posedge clk) begin
    dout_m <= 16'(addr_m);
    dout_o <= 16'(addr_o);
    dout_w <= 16'(addr_w);
  end

  int exp_k[4];
  int exp_a[4];

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] full_data(input int p);
    return {16'(12108 + p), 16'(8072 + p), 16'(4036 + p), 16'(p)};
  endfunction

  function automatic logic [63:0] wrap_data(input int p);
    return {16'(12 + p), 16'(8 + p), 16'(4 + p), 16'(p)};
  endfunction

  task automatic wait_tick_m(input string tag, output int n);
    n = 0;
    while (!tick_m && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, " tick seen"}, 96'(tick_m), 96'd1);
  endtask

  // Starts on the strobe cycle, ends on the frame_valid cycle.
  task automatic frame_m(input string tag, input int exp_lat);
    int lat;
    lat = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(negedge clk);
      for (int j = 0; j < 4; j++)
        if (exp_k[j] == k) check({tag, " addr"}, 96'(addr_m), 96'(exp_a[j]));
      if (fv_m) lat = k;
    end
    check({tag, " latency"}, 96'(lat), 96'(exp_lat));
  endtask

  task automatic wrap_frame(input string tag, input int p, input logic exp_done);
    int n;
    n = 0;
    while (!tick_w && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, " tick"}, 96'(tick_w), 96'd1);
    n = 0;
    while (!fv_w && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, " fv"}, 96'(fv_w), 96'd1);
    check({tag, " data"}, 96'(data_w), 96'(wrap_data(p)));
    check({tag, " done"}, 96'(done_w), 96'(exp_done));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int cnt;

    // Reset held with run=1
    run_m = 1'b1;
    repeat (5) @(negedge clk);
    check("rst main", {addr_m, tick_m, data_m, valid_m, fv_m, busy_m, done_m, ovr_m}, 96'd0);
    check("rst ovr",  {addr_o, tick_o, data_o, valid_o, fv_o, busy_o, done_o, ovr_o}, 96'd0);
    check("rst wrap", {addr_w, tick_w, data_w, valid_w, fv_w, busy_w, done_w, ovr_w}, 96'd0);
    rst_n = 1'b1;
    wait_tick_m("first", n);
    check("first tick delay", 96'(n), 96'd100);

    // Full mask, phase 0
    exp_k = '{2, 5, 8, 11};
    exp_a = '{0, 4036, 8072, 12108};
    frame_m("full p0", 13);
    check("full p0 data", 96'(data_m), 96'(full_data(0)));
    check("full p0 valid", 96'(valid_m), 96'hF);
    mask_m = 4'b0101;
    @(negedge clk);
    check("fv pulse", 96'({fv_m, busy_m}), 96'd0);

    // Sparse mask, phase 1
    wait_tick_m("sparse", n);
    check("tick period", 96'(n), 96'd86);
    exp_k = '{2, 6, 0, 0};
    exp_a = '{1, 8073, 0, 0};
    frame_m("sparse p1", 9);
    check("sparse data", 96'(data_m), 96'({16'd0, 16'd8073, 16'd0, 16'd1}));
    check("sparse valid", 96'(valid_m), 96'b0101);

    // Empty mask, phase 2
    mask_m = 4'b0000;
    wait_tick_m("empty", n);
    exp_k = '{0, 0, 0, 0};
    frame_m("empty p2", 5);
    check("empty valid", 96'(valid_m), 96'd0);
    check("empty data", 96'(data_m), 96'd0);

    // Full mask, phase 3 proves the empty frame advanced the phase
    mask_m = 4'hF;
    wait_tick_m("p3", n);
    exp_k = '{2, 5, 8, 11};
    exp_a = '{3, 4039, 8075, 12111};
    frame_m("full p3", 13);
    check("full p3 data", 96'(data_m), 96'(full_data(3)));
    check("main no overrun", 96'({done_m, ovr_m}), 96'd0);

    // Async reset inside WAIT of the phase 4 frame
    wait_tick_m("p4", n);
    repeat (2) @(negedge clk);
    check("in wait busy", 96'(busy_m), 96'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async rst", {addr_m, tick_m, data_m, valid_m, fv_m, busy_m, done_m, ovr_m}, 96'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_tick_m("after rst", n);
    check("after rst tick delay", 96'(n), 96'd100);
    exp_k = '{2, 5, 8, 11};
    exp_a = '{0, 4036, 8072, 12108};
    frame_m("restart p0", 13);
    check("restart data", 96'(data_m), 96'(full_data(0)));
    run_m = 1'b0;

    // Overrun with CLK_DIV=8
    run_o = 1'b1;
    n = 0;
    while (!tick_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("ovr first tick", 96'(n), 96'd8);
    check("ovr after 1st", 96'(ovr_o), 96'd0);
    @(negedge clk);
    n = 0;
    while (!tick_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("ovr 2nd tick", 96'(tick_o), 96'd1);
    check("ovr at 2nd", 96'(ovr_o), 96'd0);
    @(negedge clk);
    check("ovr set", 96'(ovr_o), 96'd1);
    run_o = 1'b0;
    repeat (40) @(negedge clk);
    check("ovr sticky", 96'(ovr_o), 96'd1);

    // Phase wrap with BAND_DEPTH=4
    run_w = 1'b1;
    wrap_frame("wrap f0", 0, 1'b0);
    wrap_frame("wrap f1", 1, 1'b0);
    wrap_frame("wrap f2", 2, 1'b0);
    wrap_frame("wrap f3", 3, 1'b1);
`ifdef BAND_SCHED_LOOP_EN
    @(negedge clk);
    check("loop done pulse", 96'(done_w), 96'd0);
    wrap_frame("wrap f4", 0, 1'b0);
`else
    cnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (fv_w) cnt++;
    end
    check("oneshot frames", 96'(cnt), 96'd0);
    check("oneshot done", 96'(done_w), 96'd1);
    check("oneshot ovr", 96'(ovr_w), 96'd0);
    run_w = 1'b0;
    repeat (2) @(negedge clk);
    check("oneshot paused done", 96'(done_w), 96'd1);
    run_w = 1'b1;
    @(negedge clk);
    check("oneshot rerun done", 96'(done_w), 96'd0);
    wrap_frame("oneshot restart", 0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
